aes_stream_driver: RTL and testbench
====================================

AES_STREAM_DRIVER -- requirements
Module: aes_stream_driver

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, meaning the maximum status polls per wait phase before the block aborts with err.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port key_load  input  1  single-cycle request to load key_in, keylen_in and encdec_in into the AES core.
REQ-005 SHALL have port key_in  input  256  key; word i (key_in[32i+31:32i]) is written to address 0x10+i.
REQ-006 SHALL have port keylen_in  input  1  0 = AES-128, 1 = AES-256.
REQ-007 SHALL have port encdec_in  input  1  1 = encrypt, 0 = decrypt.
REQ-008 SHALL have ports in_valid  input  1, in_ready  output  1 and in_block  input  128, forming the plaintext stream handshake.
REQ-009 SHALL have ports out_valid  output  1, out_ready  input  1 and out_block  output  128, forming the result stream handshake.
REQ-010 SHALL have port key_ok  output  1  high once a key has been loaded and initialised.
REQ-011 SHALL have port err  output  1  sticky timeout flag.
REQ-012 SHALL have ports aes_cs  output  1, aes_we  output  1, aes_address  output  8, aes_write_data  output  32 and aes_read_data  input  32, forming the AES register-bus master.

Function
REQ-013 SHALL master the AES bus with one access per cycle.
REQ-014 SHALL treat read data as valid exactly 1 cycle after a cycle with aes_cs=1 and aes_we=0.
REQ-015 SHALL implement FSM states IDLE, KEY_WR, CFG_WR, INIT_WR, INIT_POLL, BLK_WR, NEXT_WR, NEXT_POLL, RES_RD, OUT_HOLD and ERR.
REQ-016 SHALL move from IDLE on key_load to KEY_WR; key_load SHALL take priority over in_valid in the same cycle.
REQ-017 SHALL, in KEY_WR, write 8 words to 0x10..0x17 in ascending order, for both key lengths.
REQ-018 SHALL, in CFG_WR, write 0x0A with data {30'b0, keylen_in, encdec_in}, capturing keylen_in and encdec_in at key_load.
REQ-019 SHALL, in INIT_WR, write 0x08 with data 0x1.
REQ-020 SHALL, in INIT_POLL, wait 2 idle cycles, then repeatedly read status 0x09 until bit0 (ready) = 1.
REQ-021 SHALL, on ready in INIT_POLL, set key_ok = 1 and return to IDLE.
REQ-022 SHALL drive in_ready = 1 only in IDLE with key_ok = 1 and no key_load.
REQ-023 SHALL, on acceptance (in_valid & in_ready), capture in_block and move to BLK_WR.
REQ-024 SHALL, in BLK_WR, write 0x20..0x23 with in_block[31:0] first, ascending.
REQ-025 SHALL, in NEXT_WR, write 0x08 with data 0x2.
REQ-026 SHALL, in NEXT_POLL, wait 2 idle cycles, then poll 0x09 until bits[1:0] = 2'b11.
REQ-027 SHALL, in RES_RD, read 0x30..0x33 and assemble out_block with the word from 0x30 at bits [31:0].
REQ-028 SHALL hold out_valid = 1 and out_block stable in OUT_HOLD until out_ready = 1, then clear out_valid and return to IDLE.
REQ-029 SHALL drive aes_cs = 0, aes_we = 0, aes_address = 0 and aes_write_data = 0 on every cycle without a bus access.
REQ-030 SHALL count status reads per poll phase in a 10-bit counter that clears on phase entry.
REQ-031 SHALL, when the counter reaches TIMEOUT without success, enter ERR, set err = 1 and clear key_ok.
REQ-032 SHALL leave ERR only on key_load, which clears err and goes to KEY_WR.
REQ-033 SHALL ignore a key_load asserted outside IDLE/ERR and not queue it.
REQ-034 SHALL clear key_ok on entry to KEY_WR.
REQ-035 SHALL, with out_valid = 1 and out_ready already 1 in the first OUT_HOLD cycle, complete the transfer in that cycle.

Reset
REQ-036 SHALL, on reset assertion at any time including mid-transaction, return immediately to IDLE.
REQ-037 SHALL set on reset: in_ready = 0, out_valid = 0, out_block = 0, key_ok = 0, err = 0, aes_cs = 0, aes_we = 0, aes_address = 0 and aes_write_data = 0.
REQ-038 SHALL NOT issue any bus access in the cycle after reset deassertion.

Verification
REQ-039 SHALL pass: key_load with FIPS-197 AES-128 key 000102..0f, encdec_in = 1 -> 8 key writes, a write of 0x0A with 0x1, a write of 0x08 with 0x1; key_ok rises after a ready poll.
REQ-040 SHALL pass: with that key, in_block = 00112233..ff -> out_block = 69c4e0d8..c55a; exactly 4 block writes and 4 result reads observed.
REQ-041 SHALL pass: AES-256 key 000102..1f, in_block 00112233..ff -> out_block = 8ea2b7ca..6089, and 0x0A written with 0x3.
REQ-042 SHALL pass: bus model never sets status ready, TIMEOUT = 4 -> err = 1 after exactly 4 status reads; in_ready stays 0 until key_load.
REQ-043 SHALL pass: out_ready held 0 for 10 cycles -> out_valid and out_block stable, in_ready = 0, no bus activity.
REQ-044 SHALL pass: reset asserted during RES_RD after 2 reads -> all outputs at reset values next cycle and key_ok = 0.

Source files
------------

// File: rtl/aes_stream_driver.sv
// aes_stream_driver
//   Streams 128-bit blocks through a register-mapped AES core. A key load
//   writes the key words, the config word and the init command, then polls
//   status until the core reports ready. Each accepted input block is written
//   to the core, a "next" command is issued, status is polled until ready and
//   valid, and the four result words are read back and offered on the output
//   handshake. A poll phase that exceeds TIMEOUT status reads aborts to an
//   error state that only a new key load leaves.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   key_load              one-cycle key load request (IDLE/ERR only)
//   key_in, keylen_in,
//   encdec_in             key material and mode, captured at key_load
//   in_valid/in_ready/
//   in_block              plaintext stream in
//   out_valid/out_ready/
//   out_block             result stream out
//   key_ok                a key is loaded and initialised
//   err                   sticky timeout flag
//   aes_cs, aes_we,
//   aes_address,
//   aes_write_data,
//   aes_read_data         AES register-bus master (read data one cycle late)
module aes_stream_driver #(
   parameter int TIMEOUT = 1023
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         key_load,
   input  logic [255:0] key_in,
   input  logic         keylen_in,
   input  logic         encdec_in,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_block,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_block,
   output logic         key_ok,
   output logic         err,
   output logic         aes_cs,
   output logic         aes_we,
   output logic [7:0]   aes_address,
   output logic [31:0]  aes_write_data,
   input  logic [31:0]  aes_read_data
);

   localparam logic [9:0]  TIMEOUT_CNT = 10'(TIMEOUT);
   localparam logic [7:0]  ADDR_CTRL   = 8'h08;
   localparam logic [7:0]  ADDR_STATUS = 8'h09;
   localparam logic [7:0]  ADDR_CONFIG = 8'h0A;
   localparam logic [31:0] CTRL_INIT   = 32'h1;
   localparam logic [31:0] CTRL_NEXT   = 32'h2;
   // Poll phases: steps 0 and 1 are idle, step 2 issues the status read,
   // step 3 examines the returned word and loops back to step 2 if needed.
   localparam logic [3:0]  POLL_RD     = 4'd2;
   localparam logic [3:0]  POLL_CHK    = 4'd3;

   typedef enum logic [3:0] {
      IDLE, KEY_WR, CFG_WR, INIT_WR, INIT_POLL, BLK_WR,
      NEXT_WR, NEXT_POLL, RES_RD, OUT_HOLD, ERR
   } state_t;

   state_t           state, state_nxt;
   logic [3:0]       step;
   logic [9:0]       poll_cnt;
   logic [7:0][31:0] key_q;
   logic [3:0][31:0] blk_q;
   logic [3:0][31:0] res_q;
   logic             keylen_q, encdec_q;
   logic             key_start, accept, in_poll, poll_ok, poll_done, poll_fail;

   always_comb begin
      key_start = key_load && (state == IDLE || state == ERR);
      accept    = (state == IDLE) && key_ok && !key_load && in_valid;
      in_poll   = (state == INIT_POLL) || (state == NEXT_POLL);
      // Init only needs ready; a block needs ready and result-valid together.
      poll_ok   = (state == INIT_POLL) ? aes_read_data[0] : (aes_read_data[1:0] == 2'b11);
      poll_done = in_poll && (step == POLL_CHK) && poll_ok;
      poll_fail = in_poll && (step == POLL_CHK) && !poll_ok && (poll_cnt >= TIMEOUT_CNT);
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (key_load)                   state_nxt = KEY_WR;
                    else if (key_ok && in_valid)    state_nxt = BLK_WR;
         KEY_WR:    if (step == 4'd7)               state_nxt = CFG_WR;
         CFG_WR:                                    state_nxt = INIT_WR;
         INIT_WR:                                   state_nxt = INIT_POLL;
         INIT_POLL: if (poll_done)                  state_nxt = IDLE;
                    else if (poll_fail)             state_nxt = ERR;
         BLK_WR:    if (step == 4'd3)               state_nxt = NEXT_WR;
         NEXT_WR:                                   state_nxt = NEXT_POLL;
         NEXT_POLL: if (poll_done)                  state_nxt = RES_RD;
                    else if (poll_fail)             state_nxt = ERR;
         RES_RD:    if (step == 4'd4)               state_nxt = OUT_HOLD;
         OUT_HOLD:  if (out_ready)                  state_nxt = IDLE;
         ERR:       if (key_load)                   state_nxt = KEY_WR;
         default:                                   state_nxt = IDLE;
      endcase
   end

   // Step and poll counters plus status flags; both counters restart on any
   // state change so every phase begins from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step     <= '0;
         poll_cnt <= '0;
         key_ok   <= 1'b0;
         err      <= 1'b0;
      end else begin
         if (state_nxt != state) begin
            step     <= '0;
            poll_cnt <= '0;
         end else begin
            if (in_poll && step == POLL_CHK) step <= POLL_RD;
            else                             step <= step + 4'd1;
            if (in_poll && step == POLL_RD)  poll_cnt <= poll_cnt + 10'd1;
         end
         if (key_start) begin
            key_ok <= 1'b0;
            err    <= 1'b0;
         end else if (poll_done && state == INIT_POLL) begin
            key_ok <= 1'b1;
         end else if (poll_fail) begin
            key_ok <= 1'b0;
            err    <= 1'b1;
         end
      end
   end

   // Captured key, mode and plaintext
   always_ff @(posedge clk) begin
      if (key_start) begin
         key_q    <= key_in;
         keylen_q <= keylen_in;
         encdec_q <= encdec_in;
      end
      if (accept) blk_q <= in_block;
   end

   // Result words: the read issued at step n returns during step n+1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                           res_q <= '0;
      else if (state == RES_RD && step != 4'd0)
         res_q[step[1:0] - 2'd1] <= aes_read_data;
   end

   assign out_block = res_q;

   // Output logic
   always_comb begin
      aes_cs         = 1'b0;
      aes_we         = 1'b0;
      aes_address    = '0;
      aes_write_data = '0;
      in_ready       = 1'b0;
      out_valid      = 1'b0;
      unique case (state)
         IDLE:      in_ready = key_ok && !key_load;
         KEY_WR: begin
            aes_cs         = 1'b1;
            aes_we         = 1'b1;
            aes_address    = {5'b00010, step[2:0]};
            aes_write_data = key_q[step[2:0]];
         end
         CFG_WR: begin
            aes_cs         = 1'b1;
            aes_we         = 1'b1;
            aes_address    = ADDR_CONFIG;
            aes_write_data = {30'b0, keylen_q, encdec_q};
         end
         INIT_WR: begin
            aes_cs         = 1'b1;
            aes_we         = 1'b1;
            aes_address    = ADDR_CTRL;
            aes_write_data = CTRL_INIT;
         end
         INIT_POLL, NEXT_POLL: begin
            if (step == POLL_RD) begin
               aes_cs      = 1'b1;
               aes_address = ADDR_STATUS;
            end
         end
         BLK_WR: begin
            aes_cs         = 1'b1;
            aes_we         = 1'b1;
            aes_address    = {6'b001000, step[1:0]};
            aes_write_data = blk_q[step[1:0]];
         end
         NEXT_WR: begin
            aes_cs         = 1'b1;
            aes_we         = 1'b1;
            aes_address    = ADDR_CTRL;
            aes_write_data = CTRL_NEXT;
         end
         RES_RD: begin
            if (step < 4'd4) begin
               aes_cs      = 1'b1;
               aes_address = {6'b001100, step[1:0]};
            end
         end
         OUT_HOLD:  out_valid = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_aes_stream_driver.sv
module tb_aes_stream_driver;
   localparam int TO = 4;
   localparam logic [255:0] K128  = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
   localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic         clk = 1'b0, reset = 1'b1;
   logic         key_load = 1'b0, keylen_in = 1'b0, encdec_in = 1'b0;
   logic [255:0] key_in = '0;
   logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [127:0] in_block = '0, out_block;
   logic         key_ok, err, aes_cs, aes_we;
   logic [7:0]   aes_address;
   logic [31:0]  aes_write_data, aes_read_data = 32'h0;

   always #5 clk = ~clk;

   aes_stream_driver #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .key_load(key_load), .key_in(key_in),
      .keylen_in(keylen_in), .encdec_in(encdec_in), .in_valid(in_valid),
      .in_ready(in_ready), .in_block(in_block), .out_valid(out_valid),
      .out_ready(out_ready), .out_block(out_block), .key_ok(key_ok), .err(err),
      .aes_cs(aes_cs), .aes_we(aes_we), .aes_address(aes_address),
      .aes_write_data(aes_write_data), .aes_read_data(aes_read_data)
   );

   int total = 0, bad = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic fail_line(input string name, input logic [127:0] act);
      total++;
      bad++;
      $display("FAIL %s: got %0h, required no such event", name, act);
   endtask

   // ---------------- AES core model and transaction expectations ----------
   typedef struct packed { logic [7:0] a; logic [31:0] d; } wr_t;
   wr_t          exp_wr[$];
   logic [7:0]   exp_rd[$];
   logic [127:0] exp_out[$];
   wr_t          w;
   logic [31:0]  reg_img [256];
   logic [31:0]  res_reg [4];
   logic [31:0]  rdata_tmp;
   logic         cfg_keylen = 1'b0, in_next = 1'b0, first_poll = 1'b0;
   logic         rd_pend = 1'b0, never_ready = 1'b0, exp_ir;
   logic [7:0]   rd_addr = '0;
   int           polls_left = 0, stat_delay = 1, since_cmd = -1;
   int           n_status = 0, n_wr_blk = 0, n_rd_res = 0, n_access = 0;

   task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
      d = 32'hDEAD_BEE0;
      if (a == 8'h09) begin
         if (never_ready) d = 32'h0;
         else if (polls_left > 0) begin
            polls_left--;
            d = in_next ? 32'h1 : 32'h0;   // ready without valid during a block
         end else begin
            if (in_next) begin
               for (int i = 0; i < 4; i++)
                  res_reg[i] = cfg_keylen ? CT256[32*i +: 32] : CT128[32*i +: 32];
            end
            d = 32'h3;
         end
      end else if (a >= 8'h30 && a <= 8'h33) begin
         d = res_reg[a[1:0]];
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (rd_pend) begin
         rd_pend = 1'b0;
         bus_read(rd_addr, rdata_tmp);
         aes_read_data = rdata_tmp;
      end else begin
         aes_read_data = 32'hDEAD_BEE0;
      end
   end

   // Compare process: every cycle out of reset
   always @(negedge clk) begin
      if (!reset) begin
         if (since_cmd >= 0) since_cmd++;
         if (aes_cs) n_access++;
         if (!aes_cs) begin
            check("bus_idle_zero", {aes_we, aes_address, aes_write_data}, '0);
         end else if (aes_we) begin
            reg_img[aes_address] = aes_write_data;
            if (exp_wr.size() == 0) fail_line("unexpected_write", {aes_address, aes_write_data});
            else begin
               w = exp_wr.pop_front();
               check("bus_write", {aes_address, aes_write_data}, {w.a, w.d});
            end
            if (aes_address >= 8'h20 && aes_address <= 8'h23) n_wr_blk++;
            if (aes_address == 8'h0A) cfg_keylen = aes_write_data[1];
            if (aes_address == 8'h08) begin
               since_cmd  = 0;
               first_poll = 1'b1;
               polls_left = stat_delay;
               in_next    = aes_write_data[1];
               if (in_next) for (int i = 0; i < 4; i++) res_reg[i] = 32'h0;
            end
         end else begin
            rd_pend = 1'b1;
            rd_addr = aes_address;
            if (aes_address == 8'h09) begin
               n_status++;
               if (first_poll) begin
                  check("poll_gap", since_cmd, 3);
                  first_poll = 1'b0;
               end
            end else if (exp_rd.size() == 0) fail_line("unexpected_read", aes_address);
            else check("result_read", aes_address, exp_rd.pop_front());
            if (aes_address >= 8'h30 && aes_address <= 8'h33) n_rd_res++;
         end
         exp_ir = key_ok && !key_load && !err &&
                  exp_wr.size() == 0 && exp_rd.size() == 0 && exp_out.size() == 0;
         check("in_ready", in_ready, exp_ir);
         check("err_excl_key_ok", err && key_ok, 1'b0);
         if (out_valid) begin
            if (exp_out.size() == 0) fail_line("unexpected_out_valid", out_block);
            else begin
               check("out_block", out_block, exp_out[0]);
               if (out_ready) void'(exp_out.pop_front());
            end
         end
      end
   end

   // ---------------- directed stimulus ------------------------------------
   task automatic push_key(input logic [255:0] k, input logic kl, input logic ed);
      for (int i = 0; i < 8; i++) exp_wr.push_back({8'h10 + 8'(i), k[32*i +: 32]});
      exp_wr.push_back({8'h0A, {30'b0, kl, ed}});
      exp_wr.push_back({8'h08, 32'h1});
   endtask

   task automatic push_blk(input logic [127:0] b, input logic [127:0] ct);
      for (int i = 0; i < 4; i++) exp_wr.push_back({8'h20 + 8'(i), b[32*i +: 32]});
      exp_wr.push_back({8'h08, 32'h2});
      for (int i = 0; i < 4; i++) exp_rd.push_back(8'h30 + 8'(i));
      exp_out.push_back(ct);
   endtask

   task automatic reset_values(input string tag);
      check({tag, "_in_ready"}, in_ready, 1'b0);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_out_block"}, out_block, '0);
      check({tag, "_key_ok"}, key_ok, 1'b0);
      check({tag, "_err"}, err, 1'b0);
      check({tag, "_bus"}, {aes_cs, aes_we, aes_address, aes_write_data}, '0);
   endtask

   task automatic wait_key_or_err(input logic want_ok, input int s0);
      int n = 0;
      while (!(want_ok ? key_ok : err) && n < 200) begin @(negedge clk); #1; n++; end
      if (want_ok) begin
         check("key_ok_set", key_ok, 1'b1);
         check("init_polls", n_status - s0, stat_delay + 1);
      end else begin
         check("err_set", err, 1'b1);
         check("timeout_polls", n_status - s0, TO);
         check("key_ok_on_err", key_ok, 1'b0);
      end
      check("key_writes_done", exp_wr.size(), 0);
   endtask

   task automatic load_key(input logic [255:0] k, input logic kl, input logic ed, input logic want_ok);
      int s0 = n_status;
      @(posedge clk); #2;
      push_key(k, kl, ed);
      key_in = k; keylen_in = kl; encdec_in = ed; key_load = 1'b1;
      @(posedge clk); #2;
      key_load = 1'b0; key_in = '1; keylen_in = ~kl; encdec_in = ~ed;
      @(negedge clk);
      check("key_ok_cleared", key_ok, 1'b0);
      check("err_cleared", err, 1'b0);
      wait_key_or_err(want_ok, s0);
   endtask

   task automatic send_block(input logic [127:0] b, input logic [127:0] ct);
      int n = 0;
      @(posedge clk); #2;
      in_block = b; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      check("accept_ready", in_ready, 1'b1);
      @(posedge clk); #2;
      in_valid = 1'b0; in_block = ~b;
      push_blk(b, ct);
   endtask

   task automatic wait_out();
      int n = 0;
      while (!out_valid && n < 200) begin @(negedge clk); #1; n++; end
      check("out_valid_seen", out_valid, 1'b1);
   endtask

   initial begin
      int n, a0, b0, r0, s0;
      for (int i = 0; i < 256; i++) reg_img[i] = '0;
      for (int i = 0; i < 4; i++) res_reg[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_values("rst");
      @(posedge clk); #2 reset = 1'b0;
      @(negedge clk);
      check("no_access_after_reset", aes_cs, 1'b0);

      // AES-128 key, encrypt
      load_key(K128, 1'b0, 1'b1, 1'b1);
      check("k128_word0", reg_img[8'h10], 32'h0c0d0e0f);
      check("k128_word3", reg_img[8'h13], 32'h00010203);
      check("k128_word7", reg_img[8'h17], 32'h0);
      check("k128_cfg", reg_img[8'h0A], 32'h1);
      check("k128_init", reg_img[8'h08], 32'h1);

      // Block with held back-pressure and a stray key_load mid-operation
      b0 = n_wr_blk; r0 = n_rd_res;
      out_ready = 1'b0;
      send_block(PT, CT128);
      key_load = 1'b1;
      @(posedge clk); #2 key_load = 1'b0;
      wait_out();
      check("ct128_literal", out_block, CT128);
      @(posedge clk); #2 in_valid = 1'b1;
      @(negedge clk); #1 a0 = n_access;
      repeat (10) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1'b1);
         check("hold_block", out_block, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
         check("hold_in_ready", in_ready, 1'b0);
      end
      #1 check("hold_no_bus", n_access - a0, 0);
      @(posedge clk); #2 in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk) check("xfer_cycle_valid", out_valid, 1'b1);
      @(negedge clk) check("after_xfer_valid", out_valid, 1'b0);
      check("blk_writes", n_wr_blk - b0, 4);
      check("res_reads", n_rd_res - r0, 4);
      check("pt_word0", reg_img[8'h20], 32'hccddeeff);
      check("pt_word3", reg_img[8'h23], 32'h00112233);
      check("next_cmd", reg_img[8'h08], 32'h2);
      check("key_ok_kept", key_ok, 1'b1);

      // out_ready already high: single-cycle transfer
      send_block(PT, CT128);
      wait_out();
      n = 0;
      while (out_valid && n < 20) begin n++; @(negedge clk); end
      check("one_cycle_transfer", n, 1);

      // AES-256: key_load and in_valid together, key_load wins
      stat_delay = 2;
      s0 = n_status;
      @(posedge clk); #2;
      push_key(K256, 1'b1, 1'b1);
      key_in = K256; keylen_in = 1'b1; encdec_in = 1'b1; key_load = 1'b1;
      in_block = PT; in_valid = 1'b1;
      @(negedge clk) check("prio_in_ready", in_ready, 1'b0);
      @(posedge clk); #2 key_load = 1'b0; key_in = '0; keylen_in = 1'b0; encdec_in = 1'b0;
      @(negedge clk) check("prio_key_ok_cleared", key_ok, 1'b0);
      wait_key_or_err(1'b1, s0);
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      check("k256_accept", in_ready, 1'b1);
      @(posedge clk); #2 in_valid = 1'b0; in_block = '0;
      push_blk(PT, CT256);
      wait_out();
      check("ct256_literal", out_block, 128'h8ea2b7ca516745bfeafc49904b496089);
      check("k256_cfg", reg_img[8'h0A], 32'h3);
      check("k256_word0", reg_img[8'h10], 32'h1c1d1e1f);
      check("k256_word7", reg_img[8'h17], 32'h00010203);
      @(negedge clk);
      stat_delay = 1;

      // Reset during result readback after two reads
      r0 = n_rd_res;
      send_block(PT, CT256);
      n = 0;
      while (n_rd_res - r0 < 2 && n < 200) begin @(negedge clk); #1; n++; end
      check("two_reads_before_reset", n_rd_res - r0, 2);
      reset = 1'b1;
      #1 reset_values("mid_rst");
      exp_wr.delete(); exp_rd.delete(); exp_out.delete();
      @(posedge clk); #2 reset = 1'b0;
      @(negedge clk) check("no_access_after_mid_reset", aes_cs, 1'b0);

      // Status never ready: timeout after TO reads
      never_ready = 1'b1;
      load_key(K128, 1'b0, 1'b1, 1'b0);
      s0 = n_status;
      @(posedge clk); #2 in_valid = 1'b1; in_block = PT;
      repeat (6) begin
         @(negedge clk);
         check("err_in_ready", in_ready, 1'b0);
         check("err_sticky", err, 1'b1);
      end
      #1 check("no_polls_in_err", n_status - s0, 0);
      @(posedge clk); #2 in_valid = 1'b0;
      never_ready = 1'b0;

      // Recovery from ERR
      load_key(K128, 1'b0, 1'b1, 1'b1);
      send_block(PT, CT128);
      wait_out();
      @(negedge clk);
      @(negedge clk);
      check("queues_drained", exp_wr.size() + exp_rd.size() + exp_out.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required test completion");
      $fatal(1, "watchdog");
   end

endmodule
